// File: rtl/ppbuf_pkg.sv
// rtl/ppbuf_pkg.sv - shared defaults, reader state type and clog2 helper for the ping-pong layer buffer
package ppbuf_pkg;

  localparam int PPBUF_CH    = 16;
  localparam int PPBUF_DW    = 16;
  localparam int PPBUF_DEPTH = 3025;

  typedef enum logic {
    RD_WAIT  = 1'b0,
    RD_AVAIL = 1'b1
  } rd_state_e;

  // Never returns less than 1 so a one-word bank still has an address bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/layer_pingpong_buffer_if.sv
// rtl/layer_pingpong_buffer_if.sv - write stream and random-access read port of the ping-pong buffer
interface layer_pingpong_buffer_if
  import ppbuf_pkg::*;
#(
  parameter int WW = PPBUF_CH * PPBUF_DW,
  parameter int AW = clog2(PPBUF_DEPTH)
);
  logic          wr_valid;
  logic          wr_ready;
  logic [WW-1:0] wr_data;
  logic          wr_last;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_release;
  logic [WW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_avail;

  modport master (
    output wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_release,
    input  wr_ready, rd_data, rd_valid, rd_avail
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_release,
    output wr_ready, rd_data, rd_valid, rd_avail
  );
endinterface

// File: rtl/ppbuf_bank.sv
// rtl/ppbuf_bank.sv - one buffer bank: synchronous write port, synchronous read port with registered output
module ppbuf_bank
  import ppbuf_pkg::*;
#(
  parameter int WW    = PPBUF_CH * PPBUF_DW,
  parameter int DEPTH = PPBUF_DEPTH,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [WW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [WW-1:0] rdata_o
);
  logic [WW-1:0] mem_q [DEPTH];
  logic [WW-1:0] rdata_q;

  // Array has no reset so it maps onto block RAM; only the output register clears.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/layer_pingpong_buffer.sv
// rtl/layer_pingpong_buffer.sv - two-bank ping-pong layer buffer; PPBUF_ZERO_PAD_EN returns zero for reads past the frame
module layer_pingpong_buffer
  import ppbuf_pkg::*;
#(
  parameter int CH    = PPBUF_CH,
  parameter int DW    = PPBUF_DW,
  parameter int DEPTH = PPBUF_DEPTH,
  localparam int AW   = clog2(DEPTH),
  localparam int WW   = CH * DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AW:0]              frame_size,
  layer_pingpong_buffer_if.slave   bus,
  output logic                     wr_bank,
  output logic                     rd_bank,
  output logic [1:0]               bank_full,
  output logic [AW:0]              rd_count
);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    bank_full_q, bank_full_d;
  logic [AW:0]   size_q, size_d;
  logic [AW:0]   count_q [2];
  logic [AW:0]   count_d [2];
  rd_state_e     rd_state_q, rd_state_d;
  logic          rd_valid_q, rd_sel_q;
  logic [WW-1:0] dout0, dout1;

  logic          wr_ready_w, wr_fire, wr_first, wr_close, avail, rd_fire, rel_fire;
  logic [AW:0]   lat_size, cur_size;

  assign wr_ready_w = !bank_full_q[wr_bank_q];
  assign wr_fire    = bus.wr_valid && wr_ready_w;
  assign wr_first   = (wr_ptr_q == '0);
  assign lat_size   = (frame_size == '0 || frame_size > DEPTH_W) ? DEPTH_W : frame_size;
  // The size is taken live on the first beat so a 1-word frame can close immediately.
  assign cur_size   = wr_first ? lat_size : size_q;
  assign wr_close   = wr_fire && (bus.wr_last || ({1'b0, wr_ptr_q} == cur_size - 1'b1));
  assign avail      = (rd_state_q == RD_AVAIL);
  assign rd_fire    = bus.rd_en && avail;
  assign rel_fire   = bus.rd_release && avail;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    bank_full_d = bank_full_q;
    size_d      = size_q;
    count_d     = count_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_first) size_d = lat_size;
    end
    // A close needs an empty write bank and a release a full read bank, so they never collide.
    if (wr_close) begin
      wr_ptr_d               = '0;
      bank_full_d[wr_bank_q] = 1'b1;
      count_d[wr_bank_q]     = {1'b0, wr_ptr_q} + 1'b1;
      wr_bank_d              = ~wr_bank_q;
    end
    if (rel_fire) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end
    rd_state_d = bank_full_d[rd_bank_d] ? RD_AVAIL : RD_WAIT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_full_q <= '0;
      size_q      <= '0;
      count_q     <= '{default: '0};
      rd_state_q  <= RD_WAIT;
      rd_valid_q  <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      bank_full_q <= bank_full_d;
      size_q      <= size_d;
      count_q     <= count_d;
      rd_state_q  <= rd_state_d;
      rd_valid_q  <= rd_fire;
      if (rd_fire) rd_sel_q <= rd_bank_q;
    end
  end

  ppbuf_bank #(.WW(WW), .DEPTH(DEPTH)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_fire && !wr_bank_q),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .re_i    (rd_fire && !rd_bank_q),
    .raddr_i (bus.rd_addr),
    .rdata_o (dout0)
  );

  ppbuf_bank #(.WW(WW), .DEPTH(DEPTH)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_fire && wr_bank_q),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .re_i    (rd_fire && rd_bank_q),
    .raddr_i (bus.rd_addr),
    .rdata_o (dout1)
  );

`ifdef PPBUF_ZERO_PAD_EN
  logic pad_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         pad_q <= 1'b0;
    else if (rd_fire) pad_q <= ({1'b0, bus.rd_addr} >= count_q[rd_bank_q]);
  end

  assign bus.rd_data = pad_q ? '0 : (rd_sel_q ? dout1 : dout0);
`else
  assign bus.rd_data = rd_sel_q ? dout1 : dout0;
`endif

  assign bus.wr_ready = wr_ready_w;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_avail = avail;
  assign wr_bank      = wr_bank_q;
  assign rd_bank      = rd_bank_q;
  assign bank_full    = bank_full_q;
  assign rd_count     = avail ? count_q[rd_bank_q] : '0;
endmodule

// File: tb/tb_layer_pingpong_buffer.sv
// tb/tb_layer_pingpong_buffer.sv - directed bench for layer_pingpong_buffer (padding expectations follow PPBUF_ZERO_PAD_EN)
module tb_layer_pingpong_buffer;
  localparam int CH    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int WW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW:0]   frame_size;
  logic          wr_bank, rd_bank;
  logic [1:0]    bank_full;
  logic [AW:0]   rd_count;
  int            n_checks = 0;
  int            n_errors = 0;

  layer_pingpong_buffer_if #(.WW(WW), .AW(AW)) bus ();

  layer_pingpong_buffer #(.CH(CH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_size (frame_size),
    .bus        (bus.slave),
    .wr_bank    (wr_bank),
    .rd_bank    (rd_bank),
    .bank_full  (bank_full),
    .rd_count   (rd_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_beat(input logic [WW-1:0] d, input logic last);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_last  = last;
    step();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  task automatic rd_read(input logic [AW-1:0] a, input logic rel);
    bus.rd_en      = 1'b1;
    bus.rd_addr    = a;
    bus.rd_release = rel;
    step();
    bus.rd_en      = 1'b0;
    bus.rd_release = 1'b0;
  endtask

  task automatic release_bank();
    bus.rd_release = 1'b1;
    step();
    bus.rd_release = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    frame_size = 4'd4;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.wr_last = 1'b0;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_release = 1'b0;
    repeat (3) step();
    check("rst_bank_full", bank_full, 2'b00);
    check("rst_wr_bank", wr_bank, 0);
    check("rst_rd_bank", rd_bank, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_rd_avail", bus.rd_avail, 0);
    check("rst_rd_count", rd_count, 0);
    rst = 1'b1;
    step();
    check("rst_wr_ready", bus.wr_ready, 1);

    // Frame close into bank 0
    for (int i = 1; i <= 3; i++) wr_beat(WW'(i), 1'b0);
    check("close_not_yet", bank_full, 2'b00);
    wr_beat(16'h0004, 1'b0);
    check("close_bank_full", bank_full, 2'b01);
    check("close_wr_bank", wr_bank, 1);
    check("close_rd_avail", bus.rd_avail, 1);
    check("close_rd_count", rd_count, 4);
    rd_read(3'd2, 1'b0);
    check("read_valid", bus.rd_valid, 1);
    check("read_data", bus.rd_data, 16'h0003);
    step();
    check("read_valid_drop", bus.rd_valid, 0);

    // Backpressure: second frame fills bank 1
    for (int i = 0; i < 4; i++) wr_beat(16'h0011 + WW'(i), 1'b0);
    check("bp_bank_full", bank_full, 2'b11);
    check("bp_wr_ready", bus.wr_ready, 0);
    wr_beat(16'hDEAD, 1'b0);
    check("bp_drop_full", bank_full, 2'b11);
    check("bp_drop_wr_bank", wr_bank, 0);
    release_bank();
    check("bp_rel_wr_ready", bus.wr_ready, 1);
    check("bp_rel_full", bank_full, 2'b10);
    check("bp_rel_rd_bank", rd_bank, 1);
    check("bp_rel_count", rd_count, 4);
    rd_read(3'd0, 1'b0);
    check("bank1_addr0", bus.rd_data, 16'h0011);
    rd_read(3'd3, 1'b0);
    check("bank1_addr3", bus.rd_data, 16'h0014);

    // Drain to empty; release and read in WAIT are ignored
    release_bank();
    check("empty_full", bank_full, 2'b00);
    check("empty_rd_bank", rd_bank, 0);
    check("empty_avail", bus.rd_avail, 0);
    check("empty_count", rd_count, 0);
    release_bank();
    check("wait_rel_ignored", rd_bank, 0);
    rd_read(3'd0, 1'b0);
    check("wait_rd_ignored", bus.rd_valid, 0);

    // frame_size=0 is latched as DEPTH
    frame_size = 4'd0;
    for (int i = 0; i < 7; i++) wr_beat(16'h0030 + WW'(i), 1'b0);
    check("size0_open", bank_full, 2'b00);
    wr_beat(16'h0037, 1'b0);
    check("size0_closed", bank_full, 2'b01);
    check("size0_count", rd_count, 8);
    rd_read(3'd5, 1'b0);
    check("size0_addr5", bus.rd_data, 16'h0035);

    // Close into bank 1 while bank 0 is released
    frame_size = 4'd4;
    for (int i = 0; i < 3; i++) wr_beat(16'h0040 + WW'(i), 1'b0);
    bus.rd_release = 1'b1;
    wr_beat(16'h0043, 1'b0);
    bus.rd_release = 1'b0;
    check("simul_full", bank_full, 2'b10);
    check("simul_rd_bank", rd_bank, 1);
    check("simul_wr_bank", wr_bank, 0);
    check("simul_count", rd_count, 4);

    // Early close with wr_last on beat 3; oversize frame_size
    frame_size = 4'd10;
    wr_beat(16'h0051, 1'b0);
    wr_beat(16'h0052, 1'b0);
    wr_beat(16'h0053, 1'b1);
    check("early_full", bank_full, 2'b11);
    release_bank();
    check("early_rd_bank", rd_bank, 0);
    check("early_count", rd_count, 3);
    rd_read(3'd5, 1'b0);
    check("pad_valid", bus.rd_valid, 1);
`ifdef PPBUF_ZERO_PAD_EN
    check("pad_data", bus.rd_data, 16'h0000);
`else
    check("pad_data", bus.rd_data, 16'h0035);
`endif
    rd_read(3'd2, 1'b0);
    check("early_addr2", bus.rd_data, 16'h0053);
    rd_read(3'd1, 1'b1);
    check("rdrel_valid", bus.rd_valid, 1);
    check("rdrel_data", bus.rd_data, 16'h0052);
    check("rdrel_rd_bank", rd_bank, 1);
    check("rdrel_full", bank_full, 2'b00);
    check("rdrel_avail", bus.rd_avail, 0);

    // Reset in the middle of a frame into bank 1
    frame_size = 4'd4;
    wr_beat(16'h0061, 1'b0);
    wr_beat(16'h0062, 1'b0);
    rst = 1'b0;
    #1;
    check("mrst_wr_bank", wr_bank, 0);
    check("mrst_rd_bank", rd_bank, 0);
    check("mrst_full", bank_full, 2'b00);
    check("mrst_avail", bus.rd_avail, 0);
    check("mrst_count", rd_count, 0);
    check("mrst_valid", bus.rd_valid, 0);
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) wr_beat(16'h0071 + WW'(i), 1'b0);
    check("after_rst_open", bank_full, 2'b00);
    wr_beat(16'h0074, 1'b0);
    check("after_rst_full", bank_full, 2'b01);
    check("after_rst_count", rd_count, 4);
    check("after_rst_wr_bank", wr_bank, 1);
    rd_read(3'd0, 1'b0);
    check("after_rst_addr0", bus.rd_data, 16'h0071);
    rd_read(3'd3, 1'b0);
    check("after_rst_addr3", bus.rd_data, 16'h0074);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
